// File: rtl/clock_cal_pkg.sv
// Shared calendar constants and the Gregorian leap-year helper used by the
// month/year stage and the day counter.
package clock_cal_pkg;

  localparam int MON_W  = 4;
  localparam int YEAR_W = 14;

  localparam logic [MON_W-1:0] MON_MIN = 4'd1;
  localparam logic [MON_W-1:0] MON_MAX = 4'd12;

  typedef enum logic {
    ADJ_SEL_MON  = 1'b0,
    ADJ_SEL_YEAR = 1'b1
  } adj_sel_e;

  // Year 0 is divisible by 400, so it counts as leap.
  function automatic logic is_leap_year(input logic [YEAR_W-1:0] year);
    logic leap;
    if ((year % 14'd400) == 14'd0) begin
      leap = 1'b1;
    end else if ((year % 14'd100) == 14'd0) begin
      leap = 1'b0;
    end else if ((year % 14'd4) == 14'd0) begin
      leap = 1'b1;
    end else begin
      leap = 1'b0;
    end
    return leap;
  endfunction

endpackage

// File: rtl/count_adjust_mon_year_adj_step_gen.sv
// adj_step_gen: turns held adjust keys into single-cycle step pulses with an
// initial hold delay followed by periodic auto-repeat.
module adj_step_gen #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adj_en_i,
  input  logic adj_sel_i,
  input  logic up_i,
  input  logic down_i,
  output logic step_up_o,
  output logic step_down_o
);

  logic        req_up_s;
  logic        req_dn_s;
  logic        held_s;
  logic        fire_s;
  logic [31:0] limit_s;

  logic        prev_up_q, prev_up_d;
  logic        prev_dn_q, prev_dn_d;
  logic        prev_sel_q, prev_sel_d;
  logic        rep_q, rep_d;
  logic [31:0] cnt_q, cnt_d;

  assign req_up_s = adj_en_i & up_i & ~down_i;
  assign req_dn_s = adj_en_i & down_i & ~up_i;
  // Same direction and same field as last cycle continues a hold; anything else is a fresh press.
  assign held_s   = ((req_up_s & prev_up_q) | (req_dn_s & prev_dn_q)) & (adj_sel_i == prev_sel_q);
  assign limit_s  = rep_q ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);

  always_comb begin
    prev_up_d  = req_up_s;
    prev_dn_d  = req_dn_s;
    prev_sel_d = adj_sel_i;
    cnt_d      = 32'd0;
    rep_d      = 1'b0;
    fire_s     = 1'b0;
    if (!held_s) begin
      fire_s = req_up_s | req_dn_s;
    end else if ((cnt_q + 32'd1) == limit_s) begin
      fire_s = 1'b1;
      rep_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
      rep_d = rep_q;
    end
  end

  assign step_up_o   = fire_s & req_up_s;
  assign step_down_o = fire_s & req_dn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_up_q  <= 1'b0;
      prev_dn_q  <= 1'b0;
      prev_sel_q <= 1'b0;
      rep_q      <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      prev_up_q  <= prev_up_d;
      prev_dn_q  <= prev_dn_d;
      prev_sel_q <= prev_sel_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/count_adjust_mon_year.sv
// Month/year calendar stage fed by the day counter's end-of-month carry.
// Optional key auto-repeat for adjustment: define ADJ_AUTOREPEAT_EN.
module count_adjust_mon_year
  import clock_cal_pkg::*;
#(
  parameter int unsigned YEAR_MAX      = 9999,
  parameter int unsigned YEAR_RESET    = 2000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              carry_day,
  input  logic              adj_en,
  input  logic              adj_sel,
  input  logic              adj_up,
  input  logic              adj_down,
  output logic [MON_W-1:0]  mon,
  output logic [YEAR_W-1:0] year,
  output logic              carry_year,
  output logic              carry_century,
  output logic              is_leap
);

  localparam logic [YEAR_W-1:0] YEAR_MAX_V   = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YEAR_RESET_V = YEAR_W'(YEAR_RESET);

  if (YEAR_MAX > 16383 || YEAR_RESET > YEAR_MAX || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
    $error("count_adjust_mon_year: illegal parameter value");
  end

  logic step_up_s;
  logic step_dn_s;
  logic mon_bad_s;
  logic year_bad_s;

  logic [MON_W-1:0]  mon_q, mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              carry_year_q, carry_year_d;
  logic              carry_century_q, carry_century_d;

`ifdef ADJ_AUTOREPEAT_EN
  adj_step_gen #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_adj_step_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .adj_en_i    (adj_en),
    .adj_sel_i   (adj_sel),
    .up_i        (adj_up),
    .down_i      (adj_down),
    .step_up_o   (step_up_s),
    .step_down_o (step_dn_s)
  );
`else
  assign step_up_s = adj_up & ~adj_down;
  assign step_dn_s = adj_down & ~adj_up;
`endif

  assign mon_bad_s  = (mon_q < MON_MIN) || (mon_q > MON_MAX);
  assign year_bad_s = year_q > YEAR_MAX_V;

  always_comb begin
    mon_d           = mon_q;
    year_d          = year_q;
    carry_year_d    = 1'b0;
    carry_century_d = 1'b0;
    if (mon_bad_s || year_bad_s) begin
      mon_d  = mon_bad_s ? MON_MIN : mon_q;
      year_d = year_bad_s ? 14'd0 : year_q;
    end else if (adj_en) begin
      if (adj_sel == ADJ_SEL_YEAR) begin
        if (step_up_s) begin
          year_d = (year_q == YEAR_MAX_V) ? 14'd0 : year_q + 14'd1;
        end else if (step_dn_s) begin
          year_d = (year_q == 14'd0) ? YEAR_MAX_V : year_q - 14'd1;
        end else begin
          year_d = year_q;
        end
      end else begin
        if (step_up_s) begin
          mon_d = (mon_q == MON_MAX) ? MON_MIN : mon_q + 4'd1;
        end else if (step_dn_s) begin
          mon_d = (mon_q == MON_MIN) ? MON_MAX : mon_q - 4'd1;
        end else begin
          mon_d = mon_q;
        end
      end
    end else if (carry_day) begin
      if (mon_q == MON_MAX) begin
        mon_d        = MON_MIN;
        carry_year_d = 1'b1;
        if (year_q == YEAR_MAX_V) begin
          year_d          = 14'd0;
          carry_century_d = 1'b1;
        end else begin
          year_d = year_q + 14'd1;
        end
      end else begin
        mon_d = mon_q + 4'd1;
      end
    end else begin
      mon_d  = mon_q;
      year_d = year_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_q           <= MON_MIN;
      year_q          <= YEAR_RESET_V;
      carry_year_q    <= 1'b0;
      carry_century_q <= 1'b0;
    end else begin
      mon_q           <= mon_d;
      year_q          <= year_d;
      carry_year_q    <= carry_year_d;
      carry_century_q <= carry_century_d;
    end
  end

  assign mon           = mon_q;
  assign year          = year_q;
  assign carry_year    = carry_year_q;
  assign carry_century = carry_century_q;
  assign is_leap       = is_leap_year(year_q);

endmodule

// File: doc/count_adjust_mon_year.md
Name: count_adjust_mon_year

Overview:
- Calendar stage directly downstream of the day counter.
- Consumes the day counter's end-of-month pulse `carry_day` and maintains month (1..12) and year (0..YEAR_MAX).
- Feeds `mon`, `year` and `is_leap` back to the day counter so it can compute month length.
- Supports manual adjustment of the month or year field, selected by `adj_sel`.

Parameters:
- YEAR_MAX, 9999: highest year; year wraps YEAR_MAX -> 0; must be < 16384.
- YEAR_RESET, 2000: year value loaded on reset.
- REPEAT_DELAY, 50_000_000: cycles a key must be held before auto-repeat starts (only used with ADJ_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat steps (only used with ADJ_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- carry_day  in  1  one-cycle pulse: day wrapped from month end to day 1
- adj_en  in  1  adjust mode; when high, carry_day is ignored
- adj_sel  in  1  adjust target: 0 = month, 1 = year
- adj_up  in  1  increment request
- adj_down  in  1  decrement request
- mon  out  4  month, 1..12
- year  out  14  year, 0..YEAR_MAX
- carry_year  out  1  one-cycle pulse on month wrap 12 -> 1 in count mode
- carry_century  out  1  one-cycle pulse on year wrap YEAR_MAX -> 0 in count mode
- is_leap  out  1  leap flag for the current year

Behaviour:
- Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- Reset values: mon = 1, year = YEAR_RESET, carry_year = 0, carry_century = 0.
- Latency: all register updates occur on the clk edge that samples the request; outputs are valid the following cycle.
- Carry pulses:
  - carry_year and carry_century default to 0 every cycle.
  - Each is high for exactly one cycle, on the same edge that applies the corresponding wrap.
- Range recovery has top priority:
  - mon == 0 or mon > 12 -> mon = 1, no other action that cycle.
  - year > YEAR_MAX -> year = 0, no other action that cycle.
- Priority after range recovery: adj_en over carry_day.
- Count mode (adj_en = 0, carry_day = 1):
  - mon < 12: mon + 1.
  - mon == 12: mon = 1, carry_year = 1, and year increments on the same edge.
  - year == YEAR_MAX at that increment: year = 0, carry_century = 1 on the same edge.
- Adjust mode (adj_en = 1) — step rules:
  - A step occurs when exactly one of adj_up / adj_down is high.
  - adj_up and adj_down both high, or both low: hold.
- Adjust mode — field behaviour:
  - adj_sel = 0: month wraps 12 -> 1 on up and 1 -> 12 on down; year is unaffected.
  - adj_sel = 1: year wraps YEAR_MAX -> 0 on up and 0 -> YEAR_MAX on down.
  - No carry pulses are generated in adjust mode.
- carry_day asserted while adj_en = 1 is dropped, not queued.
- is_leap:
  - Combinational from the registered year, Gregorian rule: divisible by 400 -> 1; else divisible by 100 -> 0; else divisible by 4 -> 1; else 0.
  - Year 0 counts as leap.
- Arithmetic: unsigned; comparisons at full port width; no truncation.

Optional Feature:
- Macro: ADJ_AUTOREPEAT_EN.
- Without the macro:
  - adj_up / adj_down act as levels.
  - One step is taken on every cycle the level condition holds.
- With the macro — step generation:
  - adj_up / adj_down are held-key levels.
  - A step occurs on the rising edge of a valid single-direction request.
  - If the request is held for REPEAT_DELAY cycles, a further step occurs every REPEAT_PERIOD cycles.
- With the macro — repeat-state handling:
  - Releasing the key, changing direction, changing adj_sel, or dropping adj_en clears the repeat counter; the next request is treated as a fresh edge.
  - The repeat counter and edge-history registers reset to 0.

Decomposition:
- Package `clock_cal_pkg`: MON_W = 4, YEAR_W = 14, MON_MIN = 1, MON_MAX = 12, ADJ_SEL_MON / ADJ_SEL_YEAR constants, and an `is_leap_year(year)` function shared with the day counter.
- Sub-module `adj_step_gen` (edge detect + hold/repeat counter):
  - Instantiated only under ADJ_AUTOREPEAT_EN.
  - Outputs one-cycle step_up / step_down pulses into the counter core.

Test Plan:
- Reset -> mon = 1, year = 2000, is_leap = 1, both carries 0.
- mon = 12, year = 2023, carry_day pulse -> mon = 1, year = 2024, carry_year high for 1 cycle, is_leap = 1.
- mon = 12, year = 9999, carry_day -> mon = 1, year = 0, carry_year = 1 and carry_century = 1 on the same cycle; is_leap = 1.
- adj_en = 1, adj_sel = 1, year = 0, adj_down for 1 cycle -> year = 9999, no carries; adj_up and adj_down both high -> unchanged; carry_day during adj_en -> ignored.
- Leap checks via year adjust: 1900 -> 0, 2000 -> 1, 2024 -> 1, 2100 -> 0; adj_sel = 0, mon = 1, adj_down -> mon = 12 with year unchanged.
- With ADJ_AUTOREPEAT_EN, REPEAT_DELAY = 4, REPEAT_PERIOD = 2: adj_up held 10 cycles -> steps at cycles 0, 4, 6, 8 (4 increments); reset asserted mid-hold -> counters cleared, mon = 1.
